pe_spad_feeder: RTL and testbench
=================================

Name: pe_spad_feeder

Overview:
- Load sequencer for a single PE's filter and ifmap scratchpads.
- On start, latches the layer shape and pulses the PE's configure input, then streams p*q*S filter pixels into the filter spad.
- Then streams the initial q*S ifmap window, followed by (F-1) sliding updates of U*q pixels each.
- Sits between the global-buffer read streams (valid/ready) and the PE's wr_filter/wr_ifmap/full write interface.

Parameters:
- DATA_WIDTH, 16, pixel width.
- S_WIDTH, 5, filter-width field.
- F_WIDTH, 6, ofmap-width field.
- U_WIDTH, 3, stride field.
- p_WIDTH, 5, filters-per-PE field.
- q_WIDTH, 3, channels-per-PE field.
- CNT_WIDTH, 14, load counter width (holds p*q*S max 6727).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load job; sampled only in IDLE.
- S  in  S_WIDTH  filter width.
- F  in  F_WIDTH  ofmap width.
- U  in  U_WIDTH  stride.
- p  in  p_WIDTH  filters per PE.
- q  in  q_WIDTH  channels per PE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the job completes.
- configure  out  1  one-cycle pulse to the PE config register.
- filt_data  in  DATA_WIDTH  filter stream data.
- filt_valid  in  1  filter stream valid.
- filt_ready  out  1  filter stream ready.
- ifm_data  in  DATA_WIDTH  ifmap stream data.
- ifm_valid  in  1  ifmap stream valid.
- ifm_ready  out  1  ifmap stream ready.
- filter_pixel  out  DATA_WIDTH  to PE filter spad.
- wr_filter  out  1  filter spad write strobe.
- filter_spad_full  in  1  filter spad full/back-pressure.
- ifmap_pixel  out  DATA_WIDTH  to PE ifmap spad.
- wr_ifmap  out  1  ifmap spad write strobe.
- ifmap_spad_full  in  1  ifmap spad full (includes PE shift/reset back-pressure).

Behaviour:
- Reset (reset=0, async): state=IDLE, all counters 0, busy=0, done=0, configure=0, both readys 0, both write strobes 0, pixel outputs 0.
- Reset asserted mid-job aborts immediately with no done pulse. The PE is not notified.
- States: IDLE, CFG, LD_FILT, LD_WIN, SLIDE, FIN.
  - IDLE: when start=1, latch S,F,U,p,q into shadow registers and go to CFG. Inputs are ignored after this latch.
  - CFG: configure=1 for exactly one cycle, driving the latched values; the PE's S,F,U,p,q are driven from the shadow registers. Go to LD_FILT.
  - LD_FILT: target = p*q*S, with the product registered on the CFG cycle. filt_ready = ~filter_spad_full. A transfer occurs when filt_valid & filt_ready. After the target-th transfer, go to LD_WIN.
  - LD_WIN: target = q*S, using the ifmap stream analogously (ifm_ready = ~ifmap_spad_full). After the target-th transfer: if F<=1, go to FIN; else go to SLIDE with step counter = 1.
  - SLIDE: per step, target = U*q transfers. At step end, step counter increments. When step counter reaches F, go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
- Datapath:
  - Write path is combinational pass-through: filter_pixel=filt_data and wr_filter=filt_valid&filt_ready; same for the ifmap pair. Zero latency stream-to-spad.
  - Readys are 0 outside their load states.
  - Pixel outputs are 0 when the corresponding strobe is 0.
- Totals: filter writes = p*q*S; ifmap writes = q*S + (F-1)*U*q.
- Degenerate config: any of p,q,S = 0 makes that phase's target 0, and the phase is skipped in one cycle with no transfers. U=0 makes each SLIDE step zero-length, so SLIDE lasts F-1 cycles.
- Full asserted mid-phase stalls the phase with the counter held. The source sees ready=0; the transfer resumes when full drops.
- Valid dropping mid-phase stalls with no write and the counter held.
- start while busy is ignored.
- start on the FIN cycle is ignored; it is accepted only in IDLE.
- Counters are CNT_WIDTH wide, and products are computed at full width before truncation. Configs whose totals exceed 2^CNT_WIDTH-1 are illegal.

Test Plan:
- S=3,p=2,q=2,F=4,U=1; both streams always valid, never full -> configure pulse 1 cycle after start; 12 wr_filter cycles back-to-back; then 6+3*2=12 wr_ifmap cycles; done exactly 1 cycle after the last write; total busy = 1+12+12+1 = 26 cycles.
- Same config with filter_spad_full high for cycles 3-5 of LD_FILT -> filt_ready=0 and wr_filter=0 during those cycles; still exactly 12 filter writes, in data order 0..11.
- S=5,p=1,q=1,F=1,U=2 -> 5 filter writes, 5 ifmap writes, no SLIDE, done.
- p=0 (S=3,q=2,F=2,U=1) -> zero filter writes; 6+2=8 ifmap writes; done asserted.
- reset pulled low during SLIDE step 2 -> all outputs 0 asynchronously, no done; after release, start runs a full fresh job with correct counts.
- start held high for 30 cycles -> exactly one job, one done pulse, then a second job starts from IDLE.

Source files
------------

// File: rtl/pe_spad_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : pe_spad_feeder                                               |
// | Description : Loads one PE's filter and ifmap scratchpads from the global |
// |               buffer read streams: filter block, first window, slides.    |
// | Revision    : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
module pe_spad_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int S_WIDTH    = 5,
  parameter int F_WIDTH    = 6,
  parameter int U_WIDTH    = 3,
  parameter int p_WIDTH    = 5,
  parameter int q_WIDTH    = 3,
  parameter int CNT_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [S_WIDTH-1:0]    S,
  input  logic [F_WIDTH-1:0]    F,
  input  logic [U_WIDTH-1:0]    U,
  input  logic [p_WIDTH-1:0]    p,
  input  logic [q_WIDTH-1:0]    q,
  output logic                  busy,
  output logic                  done,
  output logic                  configure,
  output logic [S_WIDTH-1:0]    cfg_S,
  output logic [F_WIDTH-1:0]    cfg_F,
  output logic [U_WIDTH-1:0]    cfg_U,
  output logic [p_WIDTH-1:0]    cfg_p,
  output logic [q_WIDTH-1:0]    cfg_q,
  input  logic [DATA_WIDTH-1:0] filt_data,
  input  logic                  filt_valid,
  output logic                  filt_ready,
  input  logic [DATA_WIDTH-1:0] ifm_data,
  input  logic                  ifm_valid,
  output logic                  ifm_ready,
  output logic [DATA_WIDTH-1:0] filter_pixel,
  output logic                  wr_filter,
  input  logic                  filter_spad_full,
  output logic [DATA_WIDTH-1:0] ifmap_pixel,
  output logic                  wr_ifmap,
  input  logic                  ifmap_spad_full
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_cfg     = 3'd1;
  localparam logic [2:0] c_st_ld_filt = 3'd2;
  localparam logic [2:0] c_st_ld_win  = 3'd3;
  localparam logic [2:0] c_st_slide   = 3'd4;
  localparam logic [2:0] c_st_fin     = 3'd5;

  localparam int c_pqs_w  = p_WIDTH + q_WIDTH + S_WIDTH;
  localparam int c_prod_w = (c_pqs_w > CNT_WIDTH) ? c_pqs_w : CNT_WIDTH;

  logic [2:0]           r_state;
  logic [S_WIDTH-1:0]   r_s;
  logic [F_WIDTH-1:0]   r_f;
  logic [U_WIDTH-1:0]   r_u;
  logic [p_WIDTH-1:0]   r_p;
  logic [q_WIDTH-1:0]   r_q;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_tgt_filt;
  logic [CNT_WIDTH-1:0] r_tgt_win;
  logic [CNT_WIDTH-1:0] r_tgt_slide;
  logic [F_WIDTH-1:0]   r_step;

  logic [c_prod_w-1:0]  w_pqs;
  logic [c_prod_w-1:0]  w_qs;
  logic [c_prod_w-1:0]  w_uq;
  logic [CNT_WIDTH-1:0] w_tgt;
  logic                 w_last;
  logic                 w_filt_xfer;
  logic                 w_ifm_xfer;
  logic [F_WIDTH-1:0]   w_step_inc;

  // Products at full width first; legal configurations fit in CNT_WIDTH.
  assign w_pqs = c_prod_w'(r_p) * c_prod_w'(r_q) * c_prod_w'(r_s);
  assign w_qs  = c_prod_w'(r_q) * c_prod_w'(r_s);
  assign w_uq  = c_prod_w'(r_u) * c_prod_w'(r_q);

  assign w_step_inc = r_step + F_WIDTH'(1);

  always_comb begin
    w_tgt = '0;
    case (r_state)
      c_st_ld_filt: w_tgt = r_tgt_filt;
      c_st_ld_win:  w_tgt = r_tgt_win;
      c_st_slide:   w_tgt = r_tgt_slide;
      default:      w_tgt = '0;
    endcase
  end

  assign w_last = (r_cnt == (w_tgt - CNT_WIDTH'(1)));

  // A zero target blocks ready, so an empty phase passes in one idle cycle.
  always_comb begin
    filt_ready = 1'b0;
    ifm_ready  = 1'b0;
    if (r_state == c_st_ld_filt && r_tgt_filt != '0)
      filt_ready = ~filter_spad_full;
    if ((r_state == c_st_ld_win && r_tgt_win != '0) ||
        (r_state == c_st_slide  && r_tgt_slide != '0))
      ifm_ready = ~ifmap_spad_full;
  end

  assign w_filt_xfer  = filt_valid & filt_ready;
  assign w_ifm_xfer   = ifm_valid & ifm_ready;
  assign wr_filter    = w_filt_xfer;
  assign wr_ifmap     = w_ifm_xfer;
  assign filter_pixel = w_filt_xfer ? filt_data : '0;
  assign ifmap_pixel  = w_ifm_xfer ? ifm_data : '0;

  assign busy      = (r_state != c_st_idle);
  assign done      = (r_state == c_st_fin);
  assign configure = (r_state == c_st_cfg);
  assign cfg_S     = r_s;
  assign cfg_F     = r_f;
  assign cfg_U     = r_u;
  assign cfg_p     = r_p;
  assign cfg_q     = r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_st_idle;
      r_s         <= '0;
      r_f         <= '0;
      r_u         <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_tgt_filt  <= '0;
      r_tgt_win   <= '0;
      r_tgt_slide <= '0;
      r_step      <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_s     <= S;
            r_f     <= F;
            r_u     <= U;
            r_p     <= p;
            r_q     <= q;
            r_state <= c_st_cfg;
          end
        end
        c_st_cfg: begin
          r_tgt_filt  <= w_pqs[CNT_WIDTH-1:0];
          r_tgt_win   <= w_qs[CNT_WIDTH-1:0];
          r_tgt_slide <= w_uq[CNT_WIDTH-1:0];
          r_cnt       <= '0;
          r_step      <= '0;
          r_state     <= c_st_ld_filt;
        end
        c_st_ld_filt: begin
          if (r_tgt_filt == '0 || (w_filt_xfer && w_last)) begin
            r_cnt   <= '0;
            r_state <= c_st_ld_win;
          end else if (w_filt_xfer) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        c_st_ld_win: begin
          if (r_tgt_win == '0 || (w_ifm_xfer && w_last)) begin
            r_cnt <= '0;
            if (r_f <= F_WIDTH'(1)) begin
              r_state <= c_st_fin;
            end else begin
              r_step  <= F_WIDTH'(1);
              r_state <= c_st_slide;
            end
          end else if (w_ifm_xfer) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        c_st_slide: begin
          // Zero-length steps (U=0) still consume one cycle each.
          if (r_tgt_slide == '0 || (w_ifm_xfer && w_last)) begin
            r_cnt  <= '0;
            r_step <= w_step_inc;
            if (w_step_inc == r_f)
              r_state <= c_st_fin;
          end else if (w_ifm_xfer) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        c_st_fin: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_spad_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_pe_spad_feeder                                            |
// | Description : Vector table, directed corner sequences and random jobs.    |
// | Revision    : 1.0  initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pe_spad_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  S;
  logic [5:0]  F;
  logic [2:0]  U;
  logic [4:0]  p;
  logic [2:0]  q;
  logic        busy, done, configure;
  logic [4:0]  cfg_S;
  logic [5:0]  cfg_F;
  logic [2:0]  cfg_U;
  logic [4:0]  cfg_p;
  logic [2:0]  cfg_q;
  logic [15:0] filt_data, ifm_data, filter_pixel, ifmap_pixel;
  logic        filt_valid, filt_ready, ifm_valid, ifm_ready;
  logic        wr_filter, wr_ifmap, filter_spad_full, ifmap_spad_full;

  always #5 clk = ~clk;

  pe_spad_feeder dut (
    .clk(clk), .reset(reset), .start(start),
    .S(S), .F(F), .U(U), .p(p), .q(q),
    .busy(busy), .done(done), .configure(configure),
    .cfg_S(cfg_S), .cfg_F(cfg_F), .cfg_U(cfg_U), .cfg_p(cfg_p), .cfg_q(cfg_q),
    .filt_data(filt_data), .filt_valid(filt_valid), .filt_ready(filt_ready),
    .ifm_data(ifm_data), .ifm_valid(ifm_valid), .ifm_ready(ifm_ready),
    .filter_pixel(filter_pixel), .wr_filter(wr_filter), .filter_spad_full(filter_spad_full),
    .ifmap_pixel(ifmap_pixel), .wr_ifmap(wr_ifmap), .ifmap_spad_full(ifmap_spad_full)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: job totals straight from the shape arithmetic.
  function automatic int model_filt(input int s, input int p_, input int q_);
    return p_ * q_ * s;
  endfunction
  function automatic int model_ifm(input int s, input int f, input int u, input int q_);
    return q_ * s + ((f > 1) ? (f - 1) * u * q_ : 0);
  endfunction

  typedef struct {
    int nf, ni, nbusy, ncfg, ndone, cfg_cyc, done_cyc, last_wr, errs;
    bit tmo;
  } res_t;

  typedef struct {
    int s, f, u, p, q;
    int vmode, fmode;
    int exp_f, exp_i, exp_busy;
  } vec_t;

  // vmode: 1 = random valid; fmode: 1 = random full, 2 = filter full on LD_FILT cycles 3..5.
  task automatic run_job(input int s, input int f, input int u, input int p_, input int q_,
                         input int vmode, input int fmode, input int hold, input int window,
                         output res_t r);
    int cyc;
    int k;
    r = '{default: 0};
    @(negedge clk);
    S = 5'(s); F = 6'(f); U = 3'(u); p = 5'(p_); q = 3'(q_);
    start = 1'b1;
    cyc = 0;
    while (cyc < 2000 && !(window == 0 && r.ndone > 0) && !(window > 0 && cyc >= window)) begin
      @(negedge clk);
      cyc++;
      if (cyc >= hold) start = 1'b0;
      if (!start) begin
        S = 5'($urandom); F = 6'($urandom); U = 3'($urandom); p = 5'($urandom); q = 3'($urandom);
      end
      filt_valid = (vmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      ifm_valid  = (vmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      filt_data  = 16'(32'h1000 + r.nf);
      ifm_data   = 16'(32'h8000 + r.ni);
      filter_spad_full = (fmode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      ifmap_spad_full  = (fmode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      k = cyc - r.cfg_cyc;
      if (fmode == 2 && r.ncfg > 0 && k >= 3 && k <= 5) filter_spad_full = 1'b1;
      #1;
      if (busy) r.nbusy++;
      if (configure) begin
        r.ncfg++;
        if (r.ncfg == 1) r.cfg_cyc = cyc;
        if (cfg_S !== 5'(s) || cfg_F !== 6'(f) || cfg_U !== 3'(u) ||
            cfg_p !== 5'(p_) || cfg_q !== 3'(q_)) r.errs++;
      end
      if (done) begin
        r.ndone++;
        if (r.ndone == 1) r.done_cyc = cyc;
      end
      if (wr_filter !== (filt_valid && filt_ready)) r.errs++;
      if (wr_ifmap !== (ifm_valid && ifm_ready)) r.errs++;
      if (filt_ready && filter_spad_full) r.errs++;
      if (ifm_ready && ifmap_spad_full) r.errs++;
      if (!busy && (filt_ready || ifm_ready)) r.errs++;
      if (filter_pixel !== (wr_filter ? filt_data : 16'h0)) r.errs++;
      if (ifmap_pixel !== (wr_ifmap ? ifm_data : 16'h0)) r.errs++;
      if (wr_filter) begin r.nf++; r.last_wr = cyc; end
      if (wr_ifmap)  begin r.ni++; r.last_wr = cyc; end
    end
    r.tmo = (window == 0 && r.ndone == 0);
    start = 1'b0; filt_valid = 1'b0; ifm_valid = 1'b0;
    filter_spad_full = 1'b0; ifmap_spad_full = 1'b0;
  endtask

  vec_t vecs[7];
  res_t r;

  initial begin
    reset = 1'b0; start = 1'b0;
    S = '0; F = '0; U = '0; p = '0; q = '0;
    filt_data = 16'h1234; ifm_data = 16'h5678;
    filt_valid = 1'b1; ifm_valid = 1'b1;
    filter_spad_full = 1'b0; ifmap_spad_full = 1'b0;
    #23;
    check("rst_busy", int'(busy), 0);
    check("rst_outs", int'({done, configure, filt_ready, ifm_ready, wr_filter, wr_ifmap}), 0);
    check("rst_pix", int'(filter_pixel | ifmap_pixel), 0);
    @(negedge clk); reset = 1'b1;
    filt_valid = 1'b0; ifm_valid = 1'b0;

    //           s  f  u  p  q  vm fm  expF expI busy(-1 = skip)
    vecs[0] = '{3, 4, 1, 2, 2, 0, 0, 12, 12, 26};
    vecs[1] = '{3, 4, 1, 2, 2, 0, 2, 12, 12, 29};
    vecs[2] = '{5, 1, 2, 1, 1, 0, 0,  5,  5, 12};
    vecs[3] = '{3, 2, 1, 0, 2, 0, 0,  0,  8, 11};
    vecs[4] = '{4, 3, 2, 3, 0, 0, 0,  0,  0,  6};
    vecs[5] = '{2, 5, 0, 1, 3, 0, 0,  6,  6, 18};
    vecs[6] = '{2, 0, 3, 2, 1, 1, 1,  4,  2, -1};

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i].s, vecs[i].f, vecs[i].u, vecs[i].p, vecs[i].q,
              vecs[i].vmode, vecs[i].fmode, 1, 0, r);
      check($sformatf("v%0d_timeout", i), int'(r.tmo), 0);
      check($sformatf("v%0d_filt_writes", i), r.nf, vecs[i].exp_f);
      check($sformatf("v%0d_ifm_writes", i), r.ni, vecs[i].exp_i);
      check($sformatf("v%0d_protocol", i), r.errs, 0);
      check($sformatf("v%0d_done_pulses", i), r.ndone, 1);
      check($sformatf("v%0d_cfg_cycle", i), r.cfg_cyc, 1);
      check($sformatf("v%0d_done_is_last_busy", i), r.done_cyc, r.nbusy);
      if (vecs[i].exp_busy >= 0)
        check($sformatf("v%0d_busy_cycles", i), r.nbusy, vecs[i].exp_busy);
      if (vecs[i].exp_f + vecs[i].exp_i > 0 && vecs[i].vmode == 0 && vecs[i].u > 0)
        check($sformatf("v%0d_done_after_last_wr", i), r.done_cyc, r.last_wr + 1);
    end

    // Reset during SLIDE step 2: window is 6 pixels, step 1 adds 2, so 9 writes lands in step 2.
    begin
      int ni_seen;
      int done_seen;
      int cyc;
      ni_seen = 0; done_seen = 0; cyc = 0;
      @(negedge clk);
      S = 5'd3; F = 6'd4; U = 3'd1; p = 5'd2; q = 3'd2; start = 1'b1;
      while (ni_seen < 9 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        start = 1'b0;
        filt_valid = 1'b1; ifm_valid = 1'b1;
        #1;
        if (done) done_seen++;
        if (wr_ifmap) ni_seen++;
      end
      check("rst_mid_reached", ni_seen, 9);
      #2 reset = 1'b0;
      #1;
      check("rst_mid_busy", int'(busy), 0);
      check("rst_mid_ctrl", int'({done, configure, filt_ready, ifm_ready, wr_filter, wr_ifmap}), 0);
      check("rst_mid_pix", int'(filter_pixel | ifmap_pixel), 0);
      check("rst_mid_no_done", done_seen, 0);
      filt_valid = 1'b0; ifm_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      run_job(3, 4, 1, 2, 2, 0, 0, 1, 0, r);
      check("after_rst_filt", r.nf, 12);
      check("after_rst_ifm", r.ni, 12);
      check("after_rst_busy", r.nbusy, 26);
    end

    // start held for 30 cycles: one job, then a second from IDLE.
    run_job(3, 4, 1, 2, 2, 0, 0, 30, 70, r);
    check("hold_done_pulses", r.ndone, 2);
    check("hold_cfg_pulses", r.ncfg, 2);
    check("hold_first_done", r.done_cyc, 26);
    check("hold_filt", r.nf, 24);
    check("hold_ifm", r.ni, 24);
    check("hold_protocol", r.errs, 0);

    // Random shapes under random valid and back-pressure.
    for (int j = 0; j < 12; j++) begin
      int s, f, u, pp, qq;
      s  = $urandom_range(0, 6);
      f  = $urandom_range(0, 6);
      u  = $urandom_range(0, 3);
      pp = $urandom_range(0, 4);
      qq = $urandom_range(0, 3);
      run_job(s, f, u, pp, qq, 1, 1, 1, 0, r);
      check($sformatf("rnd%0d_timeout", j), int'(r.tmo), 0);
      check($sformatf("rnd%0d_filt", j), r.nf, model_filt(s, pp, qq));
      check($sformatf("rnd%0d_ifm", j), r.ni, model_ifm(s, f, u, qq));
      check($sformatf("rnd%0d_protocol", j), r.errs, 0);
      check($sformatf("rnd%0d_done", j), r.ndone, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
